issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler_pkg.sv | 30 +++
 rtl/issue_scheduler_rs_pick.sv | 43 ++++
 rtl/issue_scheduler.sv | 156 +++++++++++++++
 tb/tb_issue_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared constants, FSM state encoding and offer payload for the issue scheduler.
// Optional feature macro: ISSUE_RR_EN (round-robin row selection per FU).
package issue_scheduler_pkg;

  localparam int unsigned RS_DEPTH = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned FU_W     = 2;

  localparam logic [FU_W-1:0] FU_ALU0 = 2'd0;
  localparam logic [FU_W-1:0] FU_ALU1 = 2'd1;
  localparam logic [FU_W-1:0] FU_MEM  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } fu_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } offer_t;

  // Extract the 2-bit FU index of one RS row from the flattened request vector.
  function automatic logic [FU_W-1:0] row_fu(input logic [2*RS_DEPTH-1:0] fu_vec,
                                              input logic [IDX_W-1:0]      row);
    return fu_vec[{row, 1'b0} +: FU_W];
  endfunction

endpackage

// File: rtl/issue_scheduler_rs_pick.sv
// 16-to-1 masked row selector: fixed lowest-index priority, or round-robin
// starting at ptr+1 when ISSUE_RR_EN is defined.
module rs_pick
  import issue_scheduler_pkg::*;
(
  input  logic [RS_DEPTH-1:0] cand,
`ifdef ISSUE_RR_EN
  input  logic [IDX_W-1:0]    ptr,
`endif
  output logic                found_c,
  output logic [IDX_W-1:0]    idx_c
);

`ifdef ISSUE_RR_EN
  logic [IDX_W-1:0] row;

  // Walk offsets from farthest to nearest so the row closest after ptr wins.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    row     = '0;
    for (int i = RS_DEPTH; i >= 1; i--) begin
      row = IDX_W'(ptr + IDX_W'(i));
      if (cand[row]) begin
        found_c = 1'b1;
        idx_c   = row;
      end
    end
  end
`else
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/issue_scheduler.sv
// Per-FU issue scheduler: selects ready RS rows, holds registered offers until
// accepted, and pulses rs_clear. Optional feature macro: ISSUE_RR_EN.
module issue_scheduler #(
  parameter int unsigned RS_DEPTH = 16,
  parameter int unsigned NUM_FU   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [RS_DEPTH-1:0]   req_valid,
  input  logic [2*RS_DEPTH-1:0] req_fu,
  input  logic [NUM_FU-1:0]     fu_ready,
  input  logic                  mem_done,
  output logic [NUM_FU-1:0]     issue_valid,
  output logic [4*NUM_FU-1:0]   issue_idx,
  output logic [RS_DEPTH-1:0]   rs_clear
);
  import issue_scheduler_pkg::*;

  fu_state_e           state_q [NUM_FU];
  fu_state_e           state_d [NUM_FU];
  offer_t              offer_q [NUM_FU];
  offer_t              offer_d [NUM_FU];
  logic [RS_DEPTH-1:0] mask_q, mask_d;
  logic [RS_DEPTH-1:0] rs_clear_q, rs_clear_d;
  logic [RS_DEPTH-1:0] cand [NUM_FU];
  logic [NUM_FU-1:0]   pick_found;
  logic [IDX_W-1:0]    pick_idx [NUM_FU];
`ifdef ISSUE_RR_EN
  logic [IDX_W-1:0]    ptr_q [NUM_FU];
  logic [IDX_W-1:0]    ptr_d [NUM_FU];
`endif

  // A row is eligible only for the FU its fu_index names; index 3 matches none.
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      cand[k] = '0;
      for (int n = 0; n < RS_DEPTH; n++) begin
        cand[k][n] = req_valid[n] && !mask_q[n] &&
                     (row_fu(req_fu, IDX_W'(n)) == FU_W'(k));
      end
    end
  end

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
    rs_pick u_pick (
      .cand    (cand[k]),
`ifdef ISSUE_RR_EN
      .ptr     (ptr_q[k]),
`endif
      .found_c (pick_found[k]),
      .idx_c   (pick_idx[k])
    );
  end

  // Next-state, offer, mask and clear-pulse logic for all FUs.
  always_comb begin
    mask_d     = mask_q;
    rs_clear_d = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      state_d[k] = state_q[k];
      offer_d[k] = offer_q[k];
`ifdef ISSUE_RR_EN
      ptr_d[k]   = ptr_q[k];
`endif
    end

    for (int k = 0; k < NUM_FU; k++) begin
      case (state_q[k])
        ST_IDLE: begin
          if (pick_found[k]) begin
            state_d[k]           = ST_OFFER;
            offer_d[k].valid     = 1'b1;
            offer_d[k].idx       = pick_idx[k];
            mask_d[pick_idx[k]]  = 1'b1;
          end
        end
        ST_OFFER: begin
          // A withdrawn request wins over a same-cycle ready.
          if (!req_valid[offer_q[k].idx]) begin
            state_d[k]       = ST_IDLE;
            offer_d[k].valid = 1'b0;
          end else if (fu_ready[k]) begin
            rs_clear_d[offer_q[k].idx] = 1'b1;
            offer_d[k].valid           = 1'b0;
            state_d[k] = (FU_W'(k) == FU_MEM) ? ST_BUSY : ST_IDLE;
`ifdef ISSUE_RR_EN
            ptr_d[k]   = offer_q[k].idx;
`endif
          end
        end
        ST_BUSY: begin
          if (mem_done) begin
            state_d[k] = ST_IDLE;
          end
        end
        default: state_d[k] = ST_IDLE;
      endcase
    end

    // Masks release once the row's request has been seen low.
    for (int n = 0; n < RS_DEPTH; n++) begin
      if (!req_valid[n]) begin
        mask_d[n] = 1'b0;
      end
    end

    if (flush) begin
      mask_d     = '0;
      rs_clear_d = '0;
      for (int k = 0; k < NUM_FU; k++) begin
        state_d[k] = ST_IDLE;
        offer_d[k] = '0;
`ifdef ISSUE_RR_EN
        ptr_d[k]   = ptr_q[k];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      rs_clear_q <= '0;
      for (int k = 0; k < NUM_FU; k++) begin
        state_q[k] <= ST_IDLE;
        offer_q[k] <= '0;
`ifdef ISSUE_RR_EN
        ptr_q[k]   <= '0;
`endif
      end
    end else begin
      mask_q     <= mask_d;
      rs_clear_q <= rs_clear_d;
      for (int k = 0; k < NUM_FU; k++) begin
        state_q[k] <= state_d[k];
        offer_q[k] <= offer_d[k];
`ifdef ISSUE_RR_EN
        ptr_q[k]   <= ptr_d[k];
`endif
      end
    end
  end

  always_comb begin
    issue_valid = '0;
    issue_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      issue_valid[k]        = offer_q[k].valid;
      issue_idx[4*k +: 4]   = offer_q[k].idx;
    end
  end

  assign rs_clear = rs_clear_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler with an expected-offer queue.
// Expectations for round-robin order follow ISSUE_RR_EN when it is defined.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] req_valid = '0;
  logic [31:0] req_fu = '1;
  logic [2:0]  fu_ready = '0;
  logic        mem_done = 1'b0;
  logic [2:0]  issue_valid;
  logic [11:0] issue_idx;
  logic [15:0] rs_clear;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int fu;
    int idx;
  } exp_t;
  exp_t exp_q [$];

`ifdef ISSUE_RR_EN
  int rst_row = 1;
  int seq_exp [4] = '{3, 0, 3, 0};
`else
  int rst_row = 0;
  int seq_exp [4] = '{0, 0, 0, 0};
`endif

  issue_scheduler #(.RS_DEPTH(16), .NUM_FU(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_fu      (req_fu),
    .fu_ready    (fu_ready),
    .mem_done    (mem_done),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .rs_clear    (rs_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fu(input int row, input int fu);
    req_fu[2*row +: 2] = 2'(fu);
  endtask

  task automatic push_offer(input int fu, input int idx);
    exp_t e;
    e.fu  = fu;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expected offer and wait (bounded) for that FU to present it.
  task automatic wait_offer(input string tag);
    exp_t e;
    int   n;
    e = exp_q.pop_front();
    n = 0;
    while (issue_valid[e.fu] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(issue_valid[e.fu]), 32'd1);
    chk({tag, "_idx"}, 32'(issue_idx[4*e.fu +: 4]), 32'(e.idx));
  endtask

  task automatic idle();
    req_valid = '0;
    fu_ready  = '0;
    mem_done  = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    req_fu    = '1;
    tick();
  endtask

  initial begin
    // Reset with every row requesting FU0.
    req_valid = 16'hFFFF;
    req_fu    = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {4'd0, issue_valid, issue_idx, rs_clear}, 32'd0);
    end
    rst_n = 1'b1;
    chk("rst_release_quiet", {13'd0, issue_valid, rs_clear}, 32'd0);
    push_offer(0, rst_row);
    tick();
    chk("rst_first_offer_lat", 32'(issue_valid), 32'd1);
    wait_offer("rst_first_offer");
    idle();
    chk("flush_idle", 32'(issue_valid), 32'd0);

    // Two ALUs offered and accepted in the same cycle.
    set_fu(1, 0);
    set_fu(2, 1);
    req_valid = 16'h0006;
    push_offer(0, 1);
    push_offer(1, 2);
    tick();
    chk("dual_valid", 32'(issue_valid), 32'd3);
    wait_offer("dual_fu0");
    wait_offer("dual_fu1");
    fu_ready = 3'b011;
    tick();
    chk("dual_clear", 32'(rs_clear), 32'h0006);
    chk("dual_drop", 32'(issue_valid), 32'd0);
    req_valid = '0;
    fu_ready  = '0;
    tick();
    chk("dual_clear_pulse", 32'(rs_clear), 32'd0);
    idle();

    // Rows 0 and 3 on FU0, four request/accept rounds.
    set_fu(0, 0);
    set_fu(3, 0);
    for (int r = 0; r < 4; r++) begin
      req_valid = 16'h0009;
      push_offer(0, seq_exp[r]);
      tick();
      wait_offer($sformatf("order_r%0d", r));
      fu_ready = 3'b001;
      tick();
      chk($sformatf("order_clear_r%0d", r), 32'(rs_clear), 32'(16'd1 << seq_exp[r]));
      fu_ready  = '0;
      req_valid = '0;
      tick();
    end
    idle();

    // FU2 held offer for 5 cycles, then BUSY until mem_done.
    set_fu(5, 2);
    req_valid = 16'h0020;
    push_offer(2, 5);
    tick();
    wait_offer("mem_offer");
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("mem_hold_c%0d", c), {27'd0, issue_valid[2], issue_idx[11:8]}, 32'h15);
      if (c == 4) fu_ready = 3'b100;
      tick();
    end
    chk("mem_clear", 32'(rs_clear), 32'h0020);
    chk("mem_busy_valid", 32'(issue_valid), 32'd0);
    fu_ready  = '0;
    set_fu(6, 2);
    req_valid = 16'h0040;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mem_busy_c%0d", c), {15'd0, issue_valid[2], rs_clear}, 32'd0);
    end
    mem_done = 1'b1;
    push_offer(2, 6);
    tick();
    chk("mem_done_no_offer_yet", 32'(issue_valid[2]), 32'd0);
    mem_done = 1'b0;
    tick();
    chk("mem_reoffer_lat", 32'(issue_valid[2]), 32'd1);
    wait_offer("mem_reoffer");
    idle();

    // Request withdrawn during an offer, with ready in the same cycle.
    set_fu(8, 1);
    req_valid = 16'h0100;
    push_offer(1, 8);
    tick();
    wait_offer("wd_offer");
    req_valid = '0;
    fu_ready  = 3'b010;
    tick();
    chk("wd_valid", 32'(issue_valid[1]), 32'd0);
    chk("wd_clear", 32'(rs_clear), 32'd0);
    idle();

    // Flush coincident with accept.
    set_fu(9, 0);
    req_valid = 16'h0200;
    push_offer(0, 9);
    tick();
    wait_offer("fl_offer");
    fu_ready = 3'b001;
    flush    = 1'b1;
    tick();
    chk("fl_clear", 32'(rs_clear), 32'd0);
    chk("fl_valid", 32'(issue_valid), 32'd0);
    flush    = 1'b0;
    fu_ready = '0;
    push_offer(0, 9);
    tick();
    wait_offer("fl_reoffer");
    idle();

    // Accepted row held valid an extra cycle must not be re-offered.
    set_fu(7, 1);
    req_valid = 16'h0080;
    push_offer(1, 7);
    tick();
    wait_offer("dbl_offer");
    fu_ready = 3'b010;
    tick();
    chk("dbl_clear", 32'(rs_clear), 32'h0080);
    fu_ready = '0;
    tick();
    chk("dbl_masked", 32'(issue_valid[1]), 32'd0);
    req_valid = '0;
    tick();
    chk("dbl_low", 32'(issue_valid[1]), 32'd0);
    req_valid = 16'h0080;
    push_offer(1, 7);
    tick();
    chk("dbl_reoffer_lat", 32'(issue_valid[1]), 32'd1);
    wait_offer("dbl_reoffer");
    idle();

    // All three FUs offer and accept together.
    set_fu(10, 0);
    set_fu(11, 1);
    set_fu(12, 2);
    req_valid = 16'h1C00;
    push_offer(0, 10);
    push_offer(1, 11);
    push_offer(2, 12);
    tick();
    chk("tri_valid", 32'(issue_valid), 32'd7);
    wait_offer("tri_fu0");
    wait_offer("tri_fu1");
    wait_offer("tri_fu2");
    fu_ready = 3'b111;
    tick();
    chk("tri_clear", 32'(rs_clear), 32'h1C00);
    idle();

    // Reset asserted during an offer that is being accepted.
    set_fu(4, 0);
    req_valid = 16'h0010;
    push_offer(0, 4);
    tick();
    wait_offer("rstmid_offer");
    fu_ready = 3'b001;
    rst_n    = 1'b0;
    #1;
    chk("rstmid_valid", 32'(issue_valid), 32'd0);
    tick();
    chk("rstmid_clear", 32'(rs_clear), 32'd0);
    req_valid = '0;
    fu_ready  = '0;
    rst_n     = 1'b1;
    tick();
    chk("rstmid_after", {13'd0, issue_valid, rs_clear}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
